// File: rtl/mem_line_reader_if.sv
// rtl/mem_line_reader_if.sv - read-port and output-stream signal bundle for mem_line_reader
interface mem_line_reader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] read_addr;
  logic              read;
  logic [DATA_W-1:0] iData;
  logic              waitrequest;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output read_addr, read, out_data, out_valid,
    input  iData, waitrequest, out_ready
  );

  modport slave (
    input  read_addr, read, out_data, out_valid,
    output iData, waitrequest, out_ready
  );
endinterface

// File: rtl/mem_line_reader.sv
// rtl/mem_line_reader.sv - sequential word reader feeding a show-ahead FIFO stream
module mem_line_reader #(
  parameter int ADDR_W          = 20,
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 16,
  parameter int ADDR_STRIDE     = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         word_count,
  output logic                     busy,
  output logic                     done,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  mem_line_reader_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [CNT_W-1:0]           remaining_q, remaining_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
  logic [DATA_W-1:0]          mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, rd_req, acc, pop;

  assign fifo_full  = (level_q == (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);

  // read depends only on registered state, so it cannot change while a read is held
  assign rd_req = (state_q == S_READ) && !fifo_full;
  assign acc    = rd_req && !bus.waitrequest;
  assign pop    = !fifo_empty && bus.out_ready;

  assign bus.read      = rd_req;
  assign bus.read_addr = addr_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = !fifo_empty;
  assign fifo_level    = level_q;
  assign busy          = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done          = (state_q == S_FINISH);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    level_d     = level_q + (FIFO_DEPTH_LOG2+1)'(acc) - (FIFO_DEPTH_LOG2+1)'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            state_d     = S_READ;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_READ: begin
        if (acc) begin
          addr_d      = addr_q + ADDR_W'(ADDR_STRIDE);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty || (level_q == (FIFO_DEPTH_LOG2+1)'(1) && pop)) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      level_q     <= level_d;
      if (acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // storage needs no reset: out_data is only meaningful while out_valid
  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_ptr_q] <= bus.iData;
  end

endmodule

// File: tb/tb_mem_line_reader.sv
// tb/tb_mem_line_reader.sv - randomized and directed checks of mem_line_reader against a queue model
module tb_mem_line_reader;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy, done;
  logic [3:0]    fifo_level;
  logic          directed = 1'b1;
  logic          chk_en = 1'b0;
  int            n_pass = 0;
  int            n_total = 0;
  int            acc_cnt = 0;

  mem_line_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_line_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // memory contents as a function of address; directed mode gives 0xA0.. from base 0x100
  function automatic logic [31:0] word_of(input logic [AW-1:0] a, input logic dmode);
    logic [AW-1:0] off;
    off = (a - 20'h00100) >> 2;
    if (dmode) return 32'hA0 + 32'(off);
    return {a[11:0], 20'h0} ^ {12'h0, a} ^ 32'h5A5A_0000;
  endfunction

  assign bus.iData = word_of(bus.read_addr, directed);

  // transfer-level model: counters plus a queue standing for the buffer
  int            m_active = 0;
  int            m_done = 0;
  int            m_total = 0;
  int            m_issued = 0;
  logic [AW-1:0] m_base = '0;
  logic [31:0]   m_q[$];

  function automatic logic [AW-1:0] m_addr();
    return m_base + AW'(m_issued * 4);
  endfunction

  function automatic logic m_read();
    return (m_active != 0) && (m_issued < m_total) && (m_q.size() < 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    automatic logic acc, pop, drain;
    if (bus.read && !bus.waitrequest) acc_cnt++;
    if (reset) begin
      m_active = 0; m_done = 0; m_total = 0; m_issued = 0; m_base = '0;
      m_q.delete();
    end else begin
      acc   = m_read() && !bus.waitrequest;
      pop   = (m_q.size() != 0) && bus.out_ready;
      drain = (m_active != 0) && (m_issued == m_total);
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(word_of(m_addr(), directed));
        m_issued++;
      end
      if (m_done != 0) m_done = 0;
      else if (m_active == 0) begin
        if (start) begin
          if (word_count == '0) m_done = 1;
          else begin
            m_active = 1; m_base = base_addr; m_total = int'(word_count); m_issued = 0;
          end
        end
      end else if (drain && m_q.size() == 0) begin
        m_active = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_read", 32'(bus.read), 32'(m_read()));
      check("model_read_addr", 32'(bus.read_addr), 32'(m_addr()));
      check("model_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      check("model_level", 32'(fifo_level), 32'(m_q.size()));
      check("model_busy", 32'(busy), 32'(m_active != 0));
      check("model_done", 32'(done), 32'(m_done != 0));
      if (m_q.size() != 0) check("model_out_data", bus.out_data, m_q[0]);
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] wc);
    @(posedge clk); #1;
    base_addr = b; word_count = wc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
      @(posedge clk); #1;
      if (rnd) begin
        bus.waitrequest = ($urandom_range(0, 2) == 0);
        bus.out_ready   = ($urandom_range(0, 3) != 0);
        start           = ($urandom_range(0, 7) == 0);
        base_addr       = AW'($urandom);
        word_count      = CW'($urandom_range(0, 5));
      end
    end
    check("done_timeout", 32'(done), 32'd1);
    start = 1'b0;
  endtask

  task automatic basic_run();
    directed = 1'b1;
    do_start(20'h00100, 16'd4);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("basic_read", 32'(bus.read), 32'(n <= 4));
      if (n <= 4) check("basic_addr", 32'(bus.read_addr), 32'h100 + 32'(4 * (n - 1)));
      check("basic_valid", 32'(bus.out_valid), 32'(n >= 2 && n <= 5));
      if (n >= 2 && n <= 5) check("basic_data", bus.out_data, 32'hA0 + 32'(n - 2));
      check("basic_done", 32'(done), 32'(n == 6));
      check("basic_busy", 32'(busy), 32'(n <= 5));
      if (n < 6) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int a0;
    bus.waitrequest = 1'b0;
    bus.out_ready   = 1'b1;

    repeat (2) begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      start = 1'b1; base_addr = AW'($urandom); word_count = CW'($urandom_range(1, 9));
      bus.waitrequest = 1'($urandom); bus.out_ready = 1'($urandom);
    end
    @(negedge clk);
    check("rst_read", 32'(bus.read), 32'd0);
    check("rst_read_addr", 32'(bus.read_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; bus.waitrequest = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_start_ignored", 32'({busy, bus.read, done}), 32'd0);

    basic_run();

    directed = 1'b1;
    do_start(20'h00100, 16'd4);
    for (int n = 1; n <= 9; n++) begin
      bus.waitrequest = (n >= 2 && n <= 4);
      @(negedge clk);
      if (n >= 2 && n <= 5) begin
        check("stall_read", 32'(bus.read), 32'd1);
        check("stall_addr", 32'(bus.read_addr), 32'h104);
      end
      if (n >= 3 && n <= 5) check("stall_no_push", 32'(fifo_level), 32'd0);
      if (n == 6) check("stall_next_addr", 32'(bus.read_addr), 32'h108);
      if (n == 8) check("stall_last_data", bus.out_data, 32'hA3);
      check("stall_done", 32'(done), 32'(n == 9));
      if (n < 9) begin @(posedge clk); #1; end
    end
    bus.waitrequest = 1'b0;

    directed = 1'b0;
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    do_start(20'h02000, 16'd12);
    repeat (11) begin @(posedge clk); #1; end
    @(negedge clk);
    check("bp_accepts", 32'(acc_cnt - a0), 32'd8);
    check("bp_read_low", 32'(bus.read), 32'd0);
    check("bp_level_full", 32'(fifo_level), 32'd8);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    run_until_done(100, 1'b0);
    check("bp_all_accepts", 32'(acc_cnt - a0), 32'd12);

    do_start(20'h00500, 16'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_read", 32'(bus.read), 32'd0);

    do_start(20'h00300, 16'd5);
    base_addr = 20'h00700; word_count = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(100, 1'b0);
    check("busy_start_ignored", 32'(bus.read_addr), 32'h314);

    do_start(20'hFFFFC, 16'd2);
    @(negedge clk);
    check("wrap_addr0", 32'(bus.read_addr), 32'hFFFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_read1", 32'(bus.read), 32'd1);
    check("wrap_addr1", 32'(bus.read_addr), 32'h00000);
    run_until_done(50, 1'b0);

    do_start(20'h00400, 16'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_read", 32'(bus.read), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    basic_run();

    directed = 1'b0;
    for (int t = 0; t < 30; t++) begin
      do_start(AW'($urandom), CW'($urandom_range(0, 20)));
      run_until_done(400, 1'b1);
      bus.waitrequest = 1'b0;
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
